// File: rtl/mem_pkg.sv
// Shared op codes, FSM encoding and op helpers for the data memory access block.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } state_e;

  function automatic logic op_is_store(mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic op_is_half(mem_op_e op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic op_is_word(mem_op_e op);
    return op inside {OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load lane extraction/extension and store byte-lane merge, purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_merge,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld,
  output logic [31:0] o_st
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rword[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    o_ld   = '0;
    unique case (i_op)
      OP_LB:   o_ld = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ld = {24'd0, w_byte};
      OP_LH:   o_ld = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ld = {16'd0, w_half};
      OP_LW:   o_ld = i_rword;
      default: o_ld = '0;
    endcase
  end

  always_comb begin
    o_st = i_merge;
    unique case (i_op)
      OP_SB: o_st[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      OP_SH: begin
        if (i_off[1]) o_st[31:16] = i_wdata[15:0];
        else          o_st[15:0]  = i_wdata[15:0];
      end
      OP_SW:   o_st = i_wdata;
      default: o_st = i_merge;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data memory access controller: 1-cycle loads/SW, 2-cycle read-modify-write SB/SH.
// MEM_MISALIGN_EXC_EN enables misaligned-access flagging instead of silent alignment.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      r_state;
  state_e      w_nxt;
  logic [31:0] r_merge;
  mem_op_e     w_op;
  logic        w_mis;
  logic        w_part;
  logic        w_idle_req;
  logic        w_rmw_req;
  logic [31:0] w_ld;
  logic [31:0] w_st;

  assign w_op = mem_op_e'(op);

`ifdef MEM_MISALIGN_EXC_EN
  assign w_mis = req & ((op_is_half(w_op) & addr[0]) |
                        (op_is_word(w_op) & (|addr[1:0])));
`else
  assign w_mis = 1'b0;
`endif

  assign w_part     = req & ~w_mis & (w_op inside {OP_SB, OP_SH});
  assign w_idle_req = rst & req & (r_state == S_IDLE);
  assign w_rmw_req  = rst & req & (r_state == S_RMW_WR);

  mem_lane_align u_align (
    .i_op    (w_op),
    .i_off   (addr[1:0]),
    .i_rword (mem_rdata),
    .i_merge (r_merge),
    .i_wdata (wdata),
    .o_ld    (w_ld),
    .o_st    (w_st)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_merge <= '0;
    else if (r_state == S_IDLE && w_part)
      r_merge <= mem_rdata;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_part) w_nxt = S_RMW_WR;
      S_RMW_WR: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // rst gates every output so reset clears them without waiting for a clock
  always_comb begin
    rdata     = '0;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      w_idle_req & w_mis: begin
        misalign = 1'b1;
        done     = 1'b1;
      end
      w_idle_req & ~w_mis & ~op_is_store(w_op): begin
        mem_ce = 1'b1;
        done   = 1'b1;
        rdata  = w_ld;
      end
      w_idle_req & ~w_mis & (w_op == OP_SW): begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        done      = 1'b1;
        mem_wdata = wdata;
      end
      w_idle_req & w_part: begin
        mem_ce = 1'b1;
        stall  = 1'b1;
      end
      w_rmw_req: begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        done      = 1'b1;
        mem_wdata = w_st;
      end
      default: ;
    endcase
  end

  assign mem_addr = mem_ce ?
    {addr[31:MEM_AW+2], addr[MEM_AW+1:2], 2'b00} : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized + directed bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misalign;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [1024];
  bit          wr  [1024];
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .misalign  (misalign),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] seed(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mem_word(int i);
    return wr[i] ? mem[i] : seed(i);
  endfunction

  assign mem_rdata = mem_word(int'(mem_addr[11:2]));

  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr[mem_addr[11:2]]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit mis_of(mem_op_e o, logic [31:0] a);
    bit raw;
    raw = ((o == OP_LH || o == OP_LHU || o == OP_SH) && a[0]) ||
          ((o == OP_LW || o == OP_SW) && a[1:0] != 2'b00);
`ifdef MEM_MISALIGN_EXC_EN
    return raw;
`else
    return raw & 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(mem_op_e o, logic [31:0] w,
                                           logic [1:0] off);
    int sb = int'(off) * 8;
    int sh = off[1] ? 16 : 0;
    logic [31:0] b = (w >> sb) & 32'hFF;
    logic [31:0] h = (w >> sh) & 32'hFFFF;
    case (o)
      OP_LB:   return (b >= 128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(mem_op_e o, logic [31:0] w,
                                            logic [31:0] wd, logic [1:0] off);
    int sb = int'(off) * 8;
    int sh = off[1] ? 16 : 0;
    case (o)
      OP_SB:   return (w & ~(32'hFF << sb)) | ((wd & 32'hFF) << sb);
      OP_SH:   return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      default: return wd;
    endcase
  endfunction

  task automatic idle_chk();
    chk("idle_ce", mem_ce, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_stall", stall, 0);
    chk("idle_done", done, 0);
    chk("idle_rdata", rdata, 0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mis"}, misalign, 0);
    chk({tag, "_ce"}, mem_ce, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
  endtask

  // Entered just after a rising edge; leaves just after the completing edge.
  task automatic access(input mem_op_e o, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    int          idx = int'(a[11:2]);
    bit          m   = mis_of(o, a);
    bit          st  = o inside {OP_SB, OP_SH, OP_SW};
    logic [31:0] nw  = ref_store(o, ref_mem[idx], wd, a[1:0]);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(negedge clk);
    rd = rdata;
    chk("misalign", misalign, 32'(m));
    if (m) begin
      chk("mis_done", done, 1);
      chk("mis_we", mem_we, 0);
      chk("mis_stall", stall, 0);
      chk("mis_rdata", rdata, 0);
    end else if (!st) begin
      chk("ld_done", done, 1);
      chk("ld_stall", stall, 0);
      chk("ld_ce", mem_ce, 1);
      chk("ld_we", mem_we, 0);
      chk("ld_maddr", mem_addr, {a[31:2], 2'b00});
      chk("ld_rdata", rdata, ref_load(o, ref_mem[idx], a[1:0]));
    end else if (o == OP_SW) begin
      chk("sw_done", done, 1);
      chk("sw_stall", stall, 0);
      chk("sw_we", mem_we, 1);
      chk("sw_maddr", mem_addr, {a[31:2], 2'b00});
      chk("sw_wdata", mem_wdata, wd);
    end else begin
      chk("rd_stall", stall, 1);
      chk("rd_done", done, 0);
      chk("rd_ce", mem_ce, 1);
      chk("rd_we", mem_we, 0);
      chk("rd_maddr", mem_addr, {a[31:2], 2'b00});
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_stall", stall, 0);
      chk("wr_done", done, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_maddr", mem_addr, {a[31:2], 2'b00});
      chk("wr_wdata", mem_wdata, nw);
    end
    @(posedge clk); #1;
    req = 1'b0;
    if (st && !m) ref_mem[idx] = nw;
    chk("mem", mem_word(idx), ref_mem[idx]);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    mem_op_e     o;
    logic [31:0] a;
    rst = 1'b0; req = 1'b1; op = OP_LW; addr = 32'h104; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    zero_chk("rst");
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    idle_chk();
    chk("idle_mis", misalign, 0);
    @(posedge clk); #1;

    // V1
    access(OP_SW, 32'h100, 32'h8877_6655, rd);
    access(OP_LB, 32'h103, 32'h0, rd);
    chk("V1_lb", rd, 32'hFFFF_FF88);
    access(OP_LBU, 32'h103, 32'h0, rd);
    chk("V1_lbu", rd, 32'h0000_0088);
    access(OP_LH, 32'h102, 32'h0, rd);
    chk("V1_lh", rd, 32'hFFFF_8877);

    // V2
    access(OP_SW, 32'h200, 32'hDEAD_BEEF, rd);
    access(OP_LW, 32'h200, 32'h0, rd);
    chk("V2_lw", rd, 32'hDEAD_BEEF);

    // V3
    access(OP_SB, 32'h201, 32'h0000_0012, rd);
    chk("V3_sb", mem_word(32'h80), 32'hDEAD_12EF);
    access(OP_SH, 32'h202, 32'h0000_3456, rd);
    chk("V3_sh", mem_word(32'h80), 32'h3456_12EF);

    // V4: reset during RMW_WR aborts the write
    req = 1'b1; op = OP_SB; addr = 32'h200; wdata = 32'h0000_00AA;
    @(negedge clk);
    chk("V4_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    zero_chk("V4");
    @(posedge clk); #1;
    req = 1'b0;
    chk("V4_mem", mem_word(32'h80), 32'h3456_12EF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(OP_LW, 32'h200, 32'h0, rd);
    chk("V4_lw", rd, 32'h3456_12EF);

    // req dropped in RMW_WR: no write
    req = 1'b1; op = OP_SH; addr = 32'h200; wdata = 32'h0000_5555;
    @(negedge clk);
    chk("drop_stall", stall, 1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("drop_we", mem_we, 0);
    chk("drop_done", done, 0);
    @(posedge clk); #1;
    chk("drop_mem", mem_word(32'h80), 32'h3456_12EF);
    access(OP_LHU, 32'h202, 32'h0, rd);
    chk("drop_lhu", rd, 32'h0000_3456);

    // V5
`ifdef MEM_MISALIGN_EXC_EN
    access(OP_SW, 32'h201, 32'h1111_1111, rd);
    chk("V5_mem", mem_word(32'h80), 32'h3456_12EF);
    access(OP_LH, 32'h203, 32'h0, rd);
    chk("V5_lh", rd, 32'h0);
`else
    access(OP_LW, 32'h203, 32'h0, rd);
    chk("V5_lw", rd, 32'h3456_12EF);
`endif

    // V6: alternating SB / LW, back-to-back
    for (int i = 0; i < 8; i++) begin
      a = 32'h300 + 32'(i / 2) * 5;
      if (i % 2 == 0) access(OP_SB, a, $urandom, rd);
      else            access(OP_LW, {a[31:2], 2'b00}, 32'h0, rd);
    end

    // random traffic on a small window so stores and loads collide
    for (int i = 0; i < 400; i++) begin
      o = mem_op_e'($urandom_range(0, 7));
      a = 32'h400 + 32'($urandom_range(0, 31));
      access(o, a, $urandom, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle_chk();
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: MEM_AW, default 10, word-index width driven onto the data memory; mem_addr bits [MEM_AW+1:2] select the word.
REQ-003 Ports SHALL be, in order:
  clk  in  1  system clock, rising edge
  rst  in  1  asynchronous, active-low reset
  req  in  1  memory access request from the execute stage
  op  in  3  access type: LB, LBU, LH, LHU, LW, SB, SH, SW (codes from mem_pkg)
  addr  in  32  byte address
  wdata  in  32  store data (rt)
  rdata  out  32  load result, sign- or zero-extended
  stall  out  1  hold PC and request inputs this cycle
  done  out  1  access completes this cycle
  misalign  out  1  misaligned-access flag
  mem_ce  out  1  data memory chip enable
  mem_we  out  1  data memory write enable
  mem_addr  out  32  word-aligned memory address (bits [1:0] = 0)
  mem_wdata  out  32  memory write data
  mem_rdata  in  32  memory read data, combinational from mem_addr

Function
REQ-004 FSM states SHALL be IDLE and RMW_WR.
REQ-005 With req=0 in IDLE: mem_ce, mem_we, stall, done and misalign SHALL be 0, and rdata SHALL be 0.
REQ-006 Loads SHALL complete in IDLE in 1 cycle: mem_ce=1, mem_we=0, done=1, stall=0.
  - rdata is the lane selected by addr[1:0], little-endian.
  - LB and LH sign-extend; LBU and LHU zero-extend.
REQ-007 SW SHALL complete in IDLE in 1 cycle: mem_ce=1, mem_we=1, mem_wdata=wdata, done=1.
REQ-008 SB and SH in IDLE (read phase):
  - mem_ce=1, mem_we=0, stall=1, done=0.
  - mem_rdata is captured into merge_q at the clock edge.
  - FSM moves to RMW_WR.
REQ-009 In RMW_WR (write phase):
  - mem_ce=1, mem_we=1, stall=0, done=1.
  - mem_wdata is merge_q with the addressed byte or halfword replaced from wdata[7:0] or wdata[15:0].
  - FSM returns to IDLE at the next edge.
REQ-010 Upstream SHALL hold req, op, addr and wdata stable while stall=1; the block re-reads them in RMW_WR.
REQ-011 mem_addr SHALL equal {addr[31:2],2'b00} whenever mem_ce=1.
REQ-012 Back-to-back requests SHALL be accepted; a request in the cycle after RMW_WR is handled normally in IDLE.
REQ-013 If req falls while in RMW_WR, the block SHALL perform no write and SHALL return to IDLE.

Reset
REQ-014 rst=0 SHALL force, asynchronously:
  - state=IDLE and merge_q=0.
  - all outputs to 0: rdata, stall, done, misalign, mem_ce, mem_we, mem_addr, mem_wdata.
REQ-015 A reset asserted during RMW_WR SHALL abort the store with no memory write.

Configuration
REQ-016 Macro MEM_MISALIGN_EXC_EN SHALL control misalignment handling.
  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, SHALL in IDLE assert misalign=1 and done=1, hold mem_we=0, return rdata=0, and not enter RMW_WR.
  - Undefined: misalign SHALL be tied to 0; halfword accesses use addr[1] only and word accesses ignore addr[1:0].

Structure
REQ-017 Package mem_pkg SHALL hold the op codes (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7), the FSM state encoding and a helper flag "op is store".
REQ-018 The block SHALL contain one combinational sub-module, mem_lane_align, that does load extraction/extension and store byte-lane merging.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - V1: memory word 0x100 holds 0x8877_6655; LB addr=0x103 → rdata=0xFFFF_FF88; LBU → 0x0000_0088; LH addr=0x102 → 0xFFFF_8877, all with done in 1 cycle.
  - V2: SW addr=0x200 wdata=0xDEAD_BEEF → single cycle mem_we=1; then LW 0x200 → 0xDEAD_BEEF.
  - V3: word 0x200 = 0xDEAD_BEEF; SB addr=0x201 wdata=0x0000_0012 → stall=1 for one cycle, then write 0xDEAD_12EF with done=1; SH addr=0x202 wdata=0x3456 → 0x3456_12EF.
  - V4: SB in progress; rst pulled low while in RMW_WR → no write, outputs 0, memory unchanged, next LW returns the old value.
  - V5: MEM_MISALIGN_EXC_EN defined; SW addr=0x201 → misalign=1, done=1, mem_we=0, memory unchanged. Undefined: LW addr=0x203 returns the word at 0x200.
  - V6: alternate SB and LW for 8 requests → stall exactly on each SB's first cycle, with no lost or duplicated writes.
